// File: rtl/divider4_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding and default width.
package divider4_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divider4_ripple_subtractor.sv
// N-bit combinational subtractor built from full-subtractor cells with a rippling borrow,
// the same per-bit form the adder uses for its carry chain.
module ripple_subtractor #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         bout
);

    logic [N:0] borrow;

    assign borrow[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_cell
        assign diff[i]     = a[i] ^ b[i] ^ borrow[i];
        assign borrow[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
    end

    assign bout = borrow[N];

endmodule

// File: rtl/divider4.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake,
// divide-by-zero reported with all-ones quotient and the dividend as remainder.
module divider4
    import divider4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH:0]   r_reg;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_trial;
    logic [WIDTH:0]   r_next;
    logic [CW-1:0]    count;
    logic             bout;
    logic             accept;
    logic             zero_div;
    logic             last_iter;

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign zero_div  = (divisor == '0);
    assign last_iter = (count == CW'(1));

    // R is one bit wider than the operands so the trial subtract can never wrap.
    assign r_shift = (r_reg << 1) | {{WIDTH{1'b0}}, q_reg[WIDTH-1]};

    ripple_subtractor #(
        .N(WIDTH + 1)
    ) u_sub (
        .a   (r_shift),
        .b   ({1'b0, d_reg}),
        .diff(r_trial),
        .bout(bout)
    );

    assign r_next = bout ? r_shift : r_trial;
    assign q_next = {q_reg[WIDTH-2:0], ~bout};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = zero_div ? DONE : RUN;
            end
            RUN: begin
                if (last_iter) state_next = DONE;
            end
            DONE: begin
                if (start) state_next = zero_div ? DONE : RUN;
                else       state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Results only move on the completion edge; a start during RUN is simply not accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_reg       <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                d_reg       <= divisor;
                q_reg       <= dividend;
                r_reg       <= '0;
                count       <= CW'(WIDTH);
                div_by_zero <= zero_div;
                busy        <= ~zero_div;
                done        <= zero_div;
                if (zero_div) begin
                    quotient  <= '1;
                    remainder <= dividend;
                end
            end else if (state == RUN) begin
                q_reg <= q_next;
                r_reg <= r_next;
                count <= count - CW'(1);
                if (last_iter) begin
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    quotient  <= q_next;
                    remainder <= r_next[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_divider4.sv
// Self-checking bench for divider4: directed vector table, multi-cycle corner sequences,
// and a sweep of all operand pairs against a behavioural division model.
module tb_divider4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] dd;
        logic [3:0] ds;
        logic [3:0] exp_q;
        logic [3:0] exp_r;
        logic       exp_z;
        int         exp_lat;
    } vec_t;

    vec_t vecs[8];

    divider4 #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // One transaction: start for a single cycle, wait (bounded) for done, check results and hold.
    task automatic apply_stimulus(input logic [3:0] dd, input logic [3:0] ds,
                                  input logic [3:0] eq, input logic [3:0] er,
                                  input logic ez, input int elat, input string tag);
        int  n;
        int  busy_cycles;
        bit  got;
        @(negedge clk);
        dividend = dd;
        divisor  = ds;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        busy_cycles = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            if (done) got = 1'b1;
            else if (busy) busy_cycles++;
        end
        check_output({tag, " latency"}, 8'(got ? n : 99), 8'(elat));
        check_output({tag, " busy cycles"}, 8'(busy_cycles), 8'((elat == 1) ? 0 : 4));
        check_output({tag, " quotient"}, {4'b0, quotient}, {4'b0, eq});
        check_output({tag, " remainder"}, {4'b0, remainder}, {4'b0, er});
        check_output({tag, " div_by_zero"}, {7'b0, div_by_zero}, {7'b0, ez});
        check_output({tag, " busy at done"}, {7'b0, busy}, 8'd0);
        @(negedge clk);
        check_output({tag, " done drop"}, {7'b0, done}, 8'd0);
        check_output({tag, " quotient held"}, {4'b0, quotient}, {4'b0, eq});
        check_output({tag, " remainder held"}, {4'b0, remainder}, {4'b0, er});
    endtask

    initial begin
        int  n;
        bit  got;
        logic [3:0] mq;
        logic [3:0] mr;
        logic       mz;

        vecs[0] = '{4'd13, 4'd3,  4'd4,  4'd1,  1'b0, 5};
        vecs[1] = '{4'd15, 4'd1,  4'd15, 4'd0,  1'b0, 5};
        vecs[2] = '{4'd5,  4'd7,  4'd0,  4'd5,  1'b0, 5};
        vecs[3] = '{4'd0,  4'd9,  4'd0,  4'd0,  1'b0, 5};
        vecs[4] = '{4'd9,  4'd0,  4'd15, 4'd9,  1'b1, 1};
        vecs[5] = '{4'd15, 4'd15, 4'd1,  4'd0,  1'b0, 5};
        vecs[6] = '{4'd8,  4'd2,  4'd4,  4'd0,  1'b0, 5};
        vecs[7] = '{4'd1,  4'd15, 4'd0,  4'd1,  1'b0, 5};

        rst      = 1'b1;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        repeat (3) @(negedge clk);
        check_output("reset busy", {7'b0, busy}, 8'd0);
        check_output("reset done", {7'b0, done}, 8'd0);
        check_output("reset quotient", {4'b0, quotient}, 8'd0);
        check_output("reset remainder", {4'b0, remainder}, 8'd0);
        check_output("reset div_by_zero", {7'b0, div_by_zero}, 8'd0);
        rst = 1'b0;

        $display("[TB] directed vector table");
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].dd, vecs[i].ds, vecs[i].exp_q, vecs[i].exp_r,
                           vecs[i].exp_z, vecs[i].exp_lat, $sformatf("vec%0d", i));
        end

        $display("[TB] start during RUN is ignored");
        @(negedge clk);
        dividend = 4'd12;
        divisor  = 4'd5;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        dividend = 4'd15;
        divisor  = 4'd1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            got = done;
        end
        check_output("ignore done seen", {7'b0, got}, 8'd1);
        check_output("ignore quotient", {4'b0, quotient}, 8'd2);
        check_output("ignore remainder", {4'b0, remainder}, 8'd2);
        @(negedge clk);

        $display("[TB] reset during iteration 2");
        dividend = 4'd14;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_output("pre-reset busy", {7'b0, busy}, 8'd1);
        rst = 1'b1;
        #1;
        check_output("mid-run reset busy", {7'b0, busy}, 8'd0);
        check_output("mid-run reset done", {7'b0, done}, 8'd0);
        check_output("mid-run reset quotient", {4'b0, quotient}, 8'd0);
        check_output("mid-run reset remainder", {4'b0, remainder}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check_output("no done after reset", {7'b0, done}, 8'd0);
        end
        apply_stimulus(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 5, "after reset 14/3");

        $display("[TB] start held high back-to-back");
        @(negedge clk);
        dividend = 4'd7;
        divisor  = 4'd2;
        start    = 1'b1;
        for (int p = 0; p < 4; p++) begin
            n = 0;
            got = 1'b0;
            while (n < 20 && !got) begin
                @(negedge clk);
                n++;
                got = done;
            end
            check_output($sformatf("b2b period %0d", p), 8'(got ? n : 99), 8'd5);
            check_output($sformatf("b2b quotient %0d", p), {4'b0, quotient}, 8'd3);
            check_output($sformatf("b2b remainder %0d", p), {4'b0, remainder}, 8'd1);
        end
        start = 1'b0;
        @(negedge clk);
        check_output("b2b done drop", {7'b0, done}, 8'd0);

        $display("[TB] exhaustive sweep");
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    mq = 4'd15;
                    mr = 4'(a);
                    mz = 1'b1;
                end else begin
                    mq = 4'(a / b);
                    mr = 4'(a % b);
                    mz = 1'b0;
                end
                apply_stimulus(4'(a), 4'(b), mq, mr, mz, (b == 0) ? 1 : 5,
                               $sformatf("sweep %0d/%0d", a, b));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
